// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared types and helpers for the SCAN elevator controller.
//   state_t    : controller state (idle, moving, door open)
//   dir_t      : travel direction
//   any_beyond : true when any request bit lies strictly above (DIR_UP) or
//                strictly below (DIR_DOWN) a given floor index
// -----------------------------------------------------------------------------
package elevator_pkg;

  // Largest supported building; request vectors are zero-extended to this
  // width so one helper serves every NUM_FLOORS.
  localparam int MAX_FLOORS = 16;
  localparam int MAX_IDX_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_DOOR
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  function automatic logic any_beyond(input logic [MAX_FLOORS-1:0] req,
                                      input logic [MAX_IDX_W-1:0]  idx,
                                      input dir_t                  dir);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (req[i]) begin
        if ((dir == DIR_UP) && (i > int'(idx))) hit = 1'b1;
        if ((dir == DIR_DOWN) && (i < int'(idx))) hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// -----------------------------------------------------------------------------
// elevator_timer
// Loadable down-counter shared by travel and door dwell timing. A load takes
// priority; otherwise the count decrements and holds at zero.
// Ports:
//   i_clock     : system clock
//   i_reset_n   : asynchronous active-low reset (count -> 0)
//   i_load      : load i_load_val on the next edge
//   i_load_val  : value to load
//   o_zero      : count is zero
// -----------------------------------------------------------------------------
module elevator_timer #(
  parameter int WIDTH = 3
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/elevator_scan.sv
// -----------------------------------------------------------------------------
// elevator_scan
// N-floor elevator controller with latched floor requests and a SCAN
// scheduler: the car keeps its direction while requests remain ahead,
// serves every requested floor it passes, and reverses only when nothing
// is left ahead.
// Ports:
//   i_clock          : system clock
//   i_reset_n        : asynchronous active-low reset
//   i_req            : per-floor request buttons (one cycle latches a floor)
//   o_current_floor  : floor the car is at or last passed
//   o_moving_up      : car travelling up this cycle
//   o_moving_down    : car travelling down this cycle
//   o_door_open      : door open this cycle
//   o_pending        : latched requests not yet served
// -----------------------------------------------------------------------------
module elevator_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 5,
  parameter int DOOR_CYCLES   = 3,
  localparam int FLOOR_W      = $clog2(NUM_FLOORS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [NUM_FLOORS-1:0] i_req,
  output logic [FLOOR_W-1:0]    o_current_floor,
  output logic                  o_moving_up,
  output logic                  o_moving_down,
  output logic                  o_door_open,
  output logic [NUM_FLOORS-1:0] o_pending
);

  localparam int TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TRAVEL_LD = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0] DOOR_LD   = TMR_W'(DOOR_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  dir_t                    r_dir;
  dir_t                    w_dir_nxt;
  dir_t                    w_dir_rev;
  logic [FLOOR_W-1:0]      r_cur;
  logic [FLOOR_W-1:0]      w_cur_nxt;
  logic [FLOOR_W-1:0]      w_nf;
  logic [NUM_FLOORS-1:0]   r_pending;
  logic [NUM_FLOORS-1:0]   w_req_all;
  logic [NUM_FLOORS-1:0]   w_clear;
  logic [MAX_FLOORS-1:0]   w_req_ext;
  logic [MAX_IDX_W-1:0]    w_cur_ext;
  logic [MAX_IDX_W-1:0]    w_nf_ext;
  logic                    w_ahead_fwd;
  logic                    w_ahead_rev;
  logic                    w_ahead_nf;
  logic                    w_stop_cur;
  logic                    w_stop_nf;
  logic                    w_tmr_load;
  logic [TMR_W-1:0]        w_tmr_val;
  logic                    w_tmr_zero;

  // Live button presses count as requests in the same cycle, so a press
  // coinciding with an arrival still stops the car.
  assign w_req_all = r_pending | i_req;
  assign w_req_ext = MAX_FLOORS'(w_req_all);
  assign w_cur_ext = MAX_IDX_W'(r_cur);

  // Neighbour floor in the travel direction. It is only consumed in MOVE,
  // where a request ahead guarantees it stays inside the building.
  assign w_nf      = (r_dir == DIR_UP) ? (r_cur + FLOOR_W'(1)) : (r_cur - FLOOR_W'(1));
  assign w_nf_ext  = MAX_IDX_W'(w_nf);
  assign w_dir_rev = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;

  assign w_ahead_fwd = any_beyond(w_req_ext, w_cur_ext, r_dir);
  assign w_ahead_rev = any_beyond(w_req_ext, w_cur_ext, w_dir_rev);
  assign w_ahead_nf  = any_beyond(w_req_ext, w_nf_ext, r_dir);
  assign w_stop_cur  = w_req_ext[w_cur_ext];
  assign w_stop_nf   = w_req_ext[w_nf_ext];

  // The current floor is cleared on every door cycle, which also swallows
  // repeat presses while the door is already open.
  assign w_clear = (r_state == S_DOOR) ? (NUM_FLOORS'(1) << r_cur) : '0;

  elevator_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_dir     <= DIR_UP;
      r_cur     <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dir     <= w_dir_nxt;
      r_cur     <= w_cur_nxt;
      r_pending <= w_req_all & ~w_clear;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_cur_nxt   = r_cur;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_stop_cur) begin
          w_state_nxt = S_DOOR;
          w_tmr_load  = 1'b1;
          w_tmr_val   = DOOR_LD;
        end else if (w_ahead_fwd) begin
          w_state_nxt = S_MOVE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TRAVEL_LD;
        end else if (w_ahead_rev) begin
          // Reverse only when nothing remains in the current direction.
          w_dir_nxt   = w_dir_rev;
          w_state_nxt = S_MOVE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TRAVEL_LD;
        end
      end
      S_MOVE: begin
        if (w_tmr_zero) begin
          // Arrival decisions look at the floor being reached, not the one left.
          w_cur_nxt = w_nf;
          if (w_stop_nf) begin
            w_state_nxt = S_DOOR;
            w_tmr_load  = 1'b1;
            w_tmr_val   = DOOR_LD;
          end else if (w_ahead_nf) begin
            w_tmr_load  = 1'b1;
            w_tmr_val   = TRAVEL_LD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DOOR: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_current_floor = r_cur;
  assign o_moving_up     = (r_state == S_MOVE) && (r_dir == DIR_UP);
  assign o_moving_down   = (r_state == S_MOVE) && (r_dir == DIR_DOWN);
  assign o_door_open     = (r_state == S_DOOR);
  assign o_pending       = r_pending;

endmodule

// File: tb/tb_elevator_scan.sv
// -----------------------------------------------------------------------------
// tb_elevator_scan
// Directed bench for elevator_scan. A trip-level model (remaining cycles per
// leg, request set as a plain vector) tracks the default 8-floor instance and
// is compared every cycle; literal expectations pin key moments of each
// scenario. A second instance with 4 floors / 2-cycle travel / 1-cycle door
// is checked against a hand-written timeline.
// -----------------------------------------------------------------------------
module tb_elevator_scan;

  localparam int NF  = 8;
  localparam int TRV = 5;
  localparam int DWL = 3;

  logic          clk;
  logic          rst_n;
  logic [NF-1:0] i_req;
  logic [2:0]    o_floor;
  logic          o_up;
  logic          o_down;
  logic          o_door;
  logic [NF-1:0] o_pend;

  logic          rst2_n;
  logic [3:0]    i_req2;
  logic [1:0]    o2_floor;
  logic          o2_up;
  logic          o2_down;
  logic          o2_door;
  logic [3:0]    o2_pend;

  elevator_scan #(
    .NUM_FLOORS    (NF),
    .TRAVEL_CYCLES (TRV),
    .DOOR_CYCLES   (DWL)
  ) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_req           (i_req),
    .o_current_floor (o_floor),
    .o_moving_up     (o_up),
    .o_moving_down   (o_down),
    .o_door_open     (o_door),
    .o_pending       (o_pend)
  );

  elevator_scan #(
    .NUM_FLOORS    (4),
    .TRAVEL_CYCLES (2),
    .DOOR_CYCLES   (1)
  ) dut2 (
    .i_clock         (clk),
    .i_reset_n       (rst2_n),
    .i_req           (i_req2),
    .o_current_floor (o2_floor),
    .o_moving_up     (o2_up),
    .o_moving_down   (o2_down),
    .o_door_open     (o2_door),
    .o_pending       (o2_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
  endtask

  // ---------------- trip-level model ----------------
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic [NF-1:0] m_pend;
  logic [NF-1:0] m_all;
  int            m_cur;
  bit            m_up;
  int            m_mode;
  int            m_left;

  function automatic bit ahead_m(input logic [NF-1:0] v, input int f, input bit up);
    for (int i = 0; i < NF; i++) begin
      if (v[i] && (up ? (i > f) : (i < f))) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_cur  = 0;
    m_up   = 1'b1;
    m_mode = M_IDLE;
    m_left = 0;
  endtask

  task automatic model_step();
    m_all  = m_pend | i_req;
    m_pend = m_all;
    if (m_mode == M_DOOR) m_pend[m_cur] = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (m_all[m_cur]) begin
          m_mode = M_DOOR; m_left = DWL;
        end else if (ahead_m(m_all, m_cur, m_up)) begin
          m_mode = M_MOVE; m_left = TRV;
        end else if (ahead_m(m_all, m_cur, !m_up)) begin
          m_up = !m_up; m_mode = M_MOVE; m_left = TRV;
        end
      end
      M_MOVE: begin
        m_left--;
        if (m_left == 0) begin
          m_cur = m_up ? m_cur + 1 : m_cur - 1;
          if (m_all[m_cur]) begin
            m_mode = M_DOOR; m_left = DWL;
          end else if (ahead_m(m_all, m_cur, m_up)) begin
            m_left = TRV;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
    endcase
  endtask

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("model_floor", 32'(o_floor), 32'(m_cur));
      chk("model_up",    32'(o_up),    32'((m_mode == M_MOVE) && m_up));
      chk("model_down",  32'(o_down),  32'((m_mode == M_MOVE) && !m_up));
      chk("model_door",  32'(o_door),  32'(m_mode == M_DOOR));
      chk("model_pend",  32'(o_pend),  32'(m_pend));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic pulse(input logic [NF-1:0] v);
    i_req = v;
    tick();
    i_req = '0;
  endtask

  // Called at a falling edge; asserts reset asynchronously, checks the
  // immediate clear, and releases at the next falling edge (cycle 0).
  task automatic do_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_floor", 32'(o_floor), 32'd0);
    chk("rst_moving", 32'({o_up, o_down}), 32'd0);
    chk("rst_door", 32'(o_door), 32'd0);
    chk("rst_pend", 32'(o_pend), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  int exp_f;

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    i_req  = '0;
    i_req2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;

    // 1: single request three floors up
    do_reset();
    pulse(8'h08);
    run_until(5);
    chk("t1_c5_up", 32'({o_up, o_floor}), 32'({1'b1, 3'd0}));
    run_until(6);
    chk("t1_c6_floor", 32'(o_floor), 32'd1);
    run_until(11);
    chk("t1_c11_floor", 32'(o_floor), 32'd2);
    run_until(15);
    chk("t1_c15_up", 32'(o_up), 32'd1);
    run_until(16);
    chk("t1_c16_arrive", 32'({o_door, o_up, o_floor}), 32'({1'b1, 1'b0, 3'd3}));
    chk("t1_c16_pend", 32'(o_pend), 32'h08);
    run_until(17);
    chk("t1_c17_pend", 32'(o_pend), 32'h00);
    run_until(18);
    chk("t1_c18_door", 32'(o_door), 32'd1);
    run_until(19);
    chk("t1_c19_idle", 32'({o_door, o_up, o_down}), 32'd0);

    // 2: stops picked up on the way, then reversal
    do_reset();
    pulse(8'h20);
    run_until(12);
    chk("t2_c12_floor", 32'(o_floor), 32'd2);
    pulse(8'h12);
    run_until(21);
    chk("t2_door4", 32'({o_door, o_floor}), 32'({1'b1, 3'd4}));
    run_until(25);
    chk("t2_resume_up", 32'(o_up), 32'd1);
    run_until(30);
    chk("t2_door5", 32'({o_door, o_floor}), 32'({1'b1, 3'd5}));
    run_until(40);
    chk("t2_down", 32'({o_down, o_floor}), 32'({1'b1, 3'd4}));
    run_until(54);
    chk("t2_door1", 32'({o_door, o_floor}), 32'({1'b1, 3'd1}));
    run_until(57);
    chk("t2_end_pend", 32'(o_pend), 32'd0);

    // 3: request at the current floor, repeat press absorbed
    do_reset();
    pulse(8'h01);
    chk("t3_c1", 32'({o_door, o_up, o_down}), 32'b100);
    run_until(2);
    pulse(8'h01);
    chk("t3_c3_door", 32'(o_door), 32'd1);
    run_until(4);
    chk("t3_c4_closed", 32'({o_door, o_up, o_down}), 32'd0);
    chk("t3_c4_pend", 32'(o_pend), 32'd0);
    run_until(8);
    chk("t3_c8_closed", 32'(o_door), 32'd0);

    // 4: idle at 4 heading up, requests both sides
    do_reset();
    pulse(8'h10);
    run_until(24);
    chk("t4_idle_at4", 32'({o_door, o_up, o_floor}), 32'({1'b0, 1'b0, 3'd4}));
    pulse(8'h44);
    chk("t4_goes_up", 32'(o_up), 32'd1);
    run_until(35);
    chk("t4_door6", 32'({o_door, o_floor}), 32'({1'b1, 3'd6}));
    run_until(39);
    chk("t4_reverse", 32'(o_down), 32'd1);
    run_until(59);
    chk("t4_door2", 32'({o_door, o_floor}), 32'({1'b1, 3'd2}));
    run_until(62);
    chk("t4_end_pend", 32'(o_pend), 32'd0);

    // 5: reset in the middle of a move
    do_reset();
    pulse(8'h20);
    run_until(13);
    chk("t5_premove", 32'({o_up, o_floor}), 32'({1'b1, 3'd2}));
    do_reset();
    run_until(10);
    chk("t5_stays_idle", 32'({o_up, o_down, o_door, o_floor}), 32'd0);

    // 6: small building, hand timeline
    rst2_n = 1'b1;
    cyc = 0;
    chk("t6_c0", 32'({o2_up, o2_door, o2_floor}), 32'd0);
    i_req2 = 4'h8;
    tick();
    i_req2 = '0;
    for (int c = 1; c <= 12; c++) begin
      exp_f = (c < 3) ? 0 : (c < 5) ? 1 : (c < 7) ? 2 : 3;
      chk("t6_floor", 32'(o2_floor), 32'(exp_f));
      chk("t6_up", 32'(o2_up), 32'((c >= 1) && (c <= 6)));
      chk("t6_door", 32'(o2_door), 32'(c == 7));
      chk("t6_down", 32'(o2_down), 32'd0);
      tick();
    end
    chk("t6_pend", 32'(o2_pend), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
